// File: rtl/alu_op_sequencer.sv
// Issue/capture stage around a combinational ALU: registers one op, waits a fixed
// settle interval for the carry chain, then captures and hands off the result.
module alu_op_sequencer #(
  parameter int WIDTH         = 32,
  parameter int SETTLE_CYCLES = 16,
  parameter int CNT_W         = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [2:0]       in_sel,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_sel,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_carryout,
  input  logic             alu_overflow,
  input  logic             alu_zero,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_carryout,
  output logic             out_overflow,
  output logic             out_zero,
  output logic             busy,
  output logic [1:0]       dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid & ready are both 1;
  // a valid source holds its payload steady until then, and ready never depends on
  // the same-side valid.
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETTLE = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] LP_CNT_LOAD = CNT_W'(SETTLE_CYCLES - 1);

  state_t             r_state;
  state_t             w_next_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [WIDTH-1:0]   r_alu_a;
  logic [WIDTH-1:0]   r_alu_b;
  logic [2:0]         r_alu_sel;
  logic [WIDTH-1:0]   r_out_result;
  logic               r_out_carryout;
  logic               r_out_overflow;
  logic               r_out_zero;
  logic               r_out_valid;
  logic               w_in_ready;
  logic               w_accept;
  logic               w_capture;
  logic               w_release;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    w_in_ready   = 1'b0;
    w_accept     = 1'b0;
    w_capture    = 1'b0;
    w_release    = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_in_ready = 1'b1;
        if (in_valid) begin
          w_accept     = 1'b1;
          w_next_state = S_SETTLE;
        end
      end
      S_SETTLE: begin
        if (r_cnt == '0) begin
          w_capture    = 1'b1;
          w_next_state = S_DONE;
        end
      end
      S_DONE: begin
        // A downstream take frees the stage in the same edge, so a waiting op can
        // be accepted with no bubble.
        if (out_ready) begin
          w_in_ready = 1'b1;
          w_release  = 1'b1;
          if (in_valid) begin
            w_accept     = 1'b1;
            w_next_state = S_SETTLE;
          end else begin
            w_next_state = S_IDLE;
          end
        end
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt          <= '0;
      r_alu_a        <= '0;
      r_alu_b        <= '0;
      r_alu_sel      <= '0;
      r_out_result   <= '0;
      r_out_carryout <= 1'b0;
      r_out_overflow <= 1'b0;
      r_out_zero     <= 1'b0;
      r_out_valid    <= 1'b0;
    end else begin
      if (w_accept) begin
        r_alu_a   <= in_a;
        r_alu_b   <= in_b;
        r_alu_sel <= in_sel;
        r_cnt     <= LP_CNT_LOAD;
      end else if (r_state == S_SETTLE && r_cnt != '0) begin
        r_cnt <= r_cnt - 1'b1;
      end
      if (w_capture) begin
        r_out_result   <= alu_result;
        r_out_carryout <= alu_carryout;
        r_out_overflow <= alu_overflow;
        r_out_zero     <= alu_zero;
        r_out_valid    <= 1'b1;
      end else if (w_release) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign in_ready     = w_in_ready;
  assign alu_a        = r_alu_a;
  assign alu_b        = r_alu_b;
  assign alu_sel      = r_alu_sel;
  assign out_valid    = r_out_valid;
  assign out_result   = r_out_result;
  assign out_carryout = r_out_carryout;
  assign out_overflow = r_out_overflow;
  assign out_zero     = r_out_zero;
  assign busy         = (r_state != S_IDLE);
  assign dbg_state    = r_state;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer: behavioural ALU, vector table, corner-case sequences
// and randomized ops scored against an arithmetic reference model.
module tb_alu_op_sequencer;

  localparam int W      = 32;
  localparam int SETTLE = 16;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a, in_b;
  logic [2:0]   in_sel;
  logic [W-1:0] alu_a, alu_b;
  logic [2:0]   alu_sel;
  logic [W-1:0] alu_result;
  logic         alu_carryout, alu_overflow, alu_zero;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_result;
  logic         out_carryout, out_overflow, out_zero;
  logic         busy;
  logic [1:0]   dbg_state;

  int n_vec = 0;
  int n_err = 0;
  logic [W+2:0] exp_q[$];

  alu_op_sequencer #(.WIDTH(W), .SETTLE_CYCLES(SETTLE), .CNT_W(8)) dut (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_sel(in_sel),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
    .alu_result(alu_result), .alu_carryout(alu_carryout),
    .alu_overflow(alu_overflow), .alu_zero(alu_zero),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_carryout(out_carryout),
    .out_overflow(out_overflow), .out_zero(out_zero),
    .busy(busy), .dbg_state(dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- behavioural ALU seen by the DUT ----------------
  logic [W:0] t_sum;
  always_comb begin
    t_sum        = '0;
    alu_result   = '0;
    alu_carryout = 1'b0;
    alu_overflow = 1'b0;
    case (alu_sel)
      3'd0: begin
        t_sum        = {1'b0, alu_a} + {1'b0, alu_b};
        alu_result   = t_sum[W-1:0];
        alu_carryout = t_sum[W];
        alu_overflow = (alu_a[W-1] == alu_b[W-1]) && (t_sum[W-1] != alu_a[W-1]);
      end
      3'd1: begin
        t_sum        = {1'b0, alu_a} + {1'b0, ~alu_b} + 33'd1;
        alu_result   = t_sum[W-1:0];
        alu_carryout = t_sum[W];
        alu_overflow = (alu_a[W-1] != alu_b[W-1]) && (t_sum[W-1] != alu_a[W-1]);
      end
      3'd2: alu_result = alu_a & alu_b;
      3'd3: alu_result = alu_a | alu_b;
      3'd4: alu_result = alu_a ^ alu_b;
      default: alu_result = '0;
    endcase
    alu_zero = (alu_result == '0);
  end

  // ---------------- reference model: {carry, ovf, zero, result} ----------------
  function automatic logic [W+2:0] exp_of(logic [W-1:0] a, logic [W-1:0] b, logic [2:0] sel);
    longint ua, ub, sa, sb, f, s;
    logic [W-1:0] r;
    logic c, v;
    ua = a; ub = b;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    f = 0; s = 0; c = 1'b0; v = 1'b0;
    case (sel)
      3'd0: begin f = ua + ub; c = (f > 64'hFFFF_FFFF); s = sa + sb; end
      3'd1: begin f = ua - ub; c = (ua >= ub);          s = sa - sb; end
      3'd2: f = ua & ub;
      3'd3: f = ua | ub;
      3'd4: f = ua ^ ub;
      default: f = 0;
    endcase
    if (sel <= 3'd1) v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
    r = f[W-1:0];
    return {c, v, (r == '0), r};
  endfunction

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic sb_check();
    logic [W+2:0] e;
    if (exp_q.size() == 0) begin
      n_vec++;
      n_err++;
      $display("FAIL sb_underflow: result 0x%0h seen with empty expected queue", out_result);
    end else begin
      e = exp_q.pop_front();
      check("out_result",   out_result,   e[W-1:0]);
      check("out_carryout", out_carryout, e[W+2]);
      check("out_overflow", out_overflow, e[W+1]);
      check("out_zero",     out_zero,     e[W]);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] sel);
    int g = 0;
    in_a = a; in_b = b; in_sel = sel; in_valid = 1'b1;
    while (!in_ready && g < 100) begin tick(); g++; end
    if (g >= 100) check("accept_timeout", 64'(g), 64'd0);
    tick();
    in_valid = 1'b0;
    in_a = $urandom; in_b = $urandom; in_sel = 3'($urandom_range(0, 7));
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (!out_valid && lat < 100) begin tick(); lat++; end
  endtask

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] sel,
                        input logic [W+2:0] e, input int stall);
    int lat;
    exp_q.push_back(e);
    out_ready = (stall == 0);
    send(a, b, sel);
    wait_valid(lat);
    check("latency", 64'(lat), 64'(SETTLE));
    for (int k = 0; k < stall; k++) begin
      check("hold_valid", out_valid, 1);
      tick();
    end
    out_ready = 1'b1;
    sb_check();
    tick();
    check("valid_drop", out_valid, 0);
    check("idle_busy", busy, 0);
  endtask

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [2:0]   sel;
    logic [W-1:0] res;
    logic         c;
    logic         v;
    logic         z;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int  lat;
    bit  seen;

    vecs[0] = '{32'h0000_0001, 32'h0000_0001, 3'd0, 32'h0000_0002, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{32'h7FFF_FFFF, 32'h0000_0001, 3'd0, 32'h8000_0000, 1'b0, 1'b1, 1'b0};
    vecs[2] = '{32'h0000_0005, 32'h0000_0005, 3'd1, 32'h0000_0000, 1'b1, 1'b0, 1'b1};
    vecs[3] = '{32'hFFFF_FFFF, 32'h0000_0001, 3'd0, 32'h0000_0000, 1'b1, 1'b0, 1'b1};
    vecs[4] = '{32'h0000_0000, 32'h0000_0001, 3'd1, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0};
    vecs[5] = '{32'h8000_0000, 32'h0000_0001, 3'd1, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0};
    vecs[6] = '{32'hF0F0_F0F0, 32'h0FF0_0FF0, 3'd2, 32'h00F0_00F0, 1'b0, 1'b0, 1'b0};
    vecs[7] = '{32'h8000_0000, 32'h8000_0000, 3'd0, 32'h0000_0000, 1'b1, 1'b1, 1'b1};

    // reset
    reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_a = '0; in_b = '0; in_sel = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_alu_a", alu_a, 0);
    check("rst_out_result", out_result, 0);
    reset_n = 1'b1;
    #1;
    check("rst_in_ready", in_ready, 1);
    tick();

    // vector table
    for (int i = 0; i < 8; i++)
      run_op(vecs[i].a, vecs[i].b, vecs[i].sel,
             {vecs[i].c, vecs[i].v, vecs[i].z, vecs[i].res}, i % 2);

    // reset while idle clears everything captured so far
    reset_n = 1'b0;
    #1;
    check("idle_rst_out_result", out_result, 0);
    check("idle_rst_out_carry", out_carryout, 0);
    check("idle_rst_out_ovf", out_overflow, 0);
    check("idle_rst_out_zero", out_zero, 0);
    check("idle_rst_alu_a", alu_a, 0);
    check("idle_rst_alu_b", alu_b, 0);
    check("idle_rst_alu_sel", alu_sel, 0);
    check("idle_rst_busy", busy, 0);
    #2;
    reset_n = 1'b1;
    #1;
    check("idle_rst_in_ready", in_ready, 1);
    tick();

    // backpressure with input churn
    out_ready = 1'b0;
    exp_q.push_back(exp_of(32'd9, 32'd6, 3'd1));
    send(32'd9, 32'd6, 3'd1);
    wait_valid(lat);
    check("bp_latency", 64'(lat), 64'(SETTLE));
    for (int k = 0; k < 5; k++) begin
      in_valid = 1'b1;
      in_a = $urandom; in_b = $urandom; in_sel = 3'($urandom_range(0, 7));
      #1;
      check("bp_in_ready", in_ready, 0);
      tick();
      check("bp_out_valid", out_valid, 1);
      check("bp_alu_a", alu_a, 9);
      check("bp_alu_b", alu_b, 6);
      check("bp_alu_sel", alu_sel, 1);
      check("bp_out_result", out_result, 3);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    sb_check();
    tick();
    check("bp_valid_drop", out_valid, 0);

    // zero-bubble back-to-back
    out_ready = 1'b0;
    exp_q.push_back(exp_of(32'd10, 32'd20, 3'd0));
    send(32'd10, 32'd20, 3'd0);
    wait_valid(lat);
    check("zb_first_latency", 64'(lat), 64'(SETTLE));
    exp_q.push_back({1'b0, 1'b0, 1'b0, 32'd7});
    in_a = 32'd3; in_b = 32'd4; in_sel = 3'd0; in_valid = 1'b1; out_ready = 1'b1;
    #1;
    check("zb_in_ready", in_ready, 1);
    sb_check();
    tick();
    in_valid = 1'b0;
    check("zb_valid_low", out_valid, 0);
    check("zb_busy", busy, 1);
    check("zb_alu_a", alu_a, 3);
    check("zb_alu_b", alu_b, 4);
    wait_valid(lat);
    check("zb_latency", 64'(lat), 64'(SETTLE));
    sb_check();
    tick();
    check("zb_valid_drop", out_valid, 0);

    // reset mid-settle drops the op
    send(32'd2, 32'd2, 3'd0);
    repeat (8) tick();
    check("mid_busy", busy, 1);
    reset_n = 1'b0;
    #1;
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_alu_a", alu_a, 0);
    check("mid_rst_in_ready", in_ready, 1);
    #2;
    reset_n = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (out_valid) seen = 1'b1;
    end
    check("mid_rst_no_valid", seen, 0);
    run_op(32'h11, 32'h22, 3'd0, exp_of(32'h11, 32'h22, 3'd0), 0);

    // randomized ops against the reference model
    for (int i = 0; i < 40; i++) begin
      logic [W-1:0] a, b;
      logic [2:0]   sel;
      a   = $urandom;
      b   = (i % 5 == 0) ? a : $urandom;
      sel = 3'($urandom_range(0, 4));
      repeat ($urandom_range(0, 2)) tick();
      run_op(a, b, sel, exp_of(a, b, sel), $urandom_range(0, 3));
    end

    check("sb_drained", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
